// File: rtl/life_if.sv
// Seed/generation bundle for the life engine: the seed pattern goes in, the current
// generation comes out. Indexing is [row][col] on both grids.
interface life_if #(
    parameter int ROWS = 10,
    parameter int COLS = 10
);
    logic [ROWS-1:0][COLS-1:0] init;
    logic [ROWS-1:0][COLS-1:0] nextstate;

    modport master (output init, input  nextstate);
    modport slave  (input  init, output nextstate);
endinterface

// File: rtl/life.sv
// Conway's Game of Life on a ROWS x COLS register grid: one generation per clock edge.
// Define LIFE_TORUS_EN for a wrap-around (toroidal) boundary; the default treats off-grid cells as dead.
module life #(
    parameter int ROWS = 10,
    parameter int COLS = 10
) (
    input  logic  clk,
    input  logic  reset,
    life_if.slave ifc
);

    logic [ROWS-1:0][COLS-1:0] grid_q, grid_d;
    logic [ROWS-1:0][COLS-1:0] next_grid;
    logic                      loaded_q, loaded_d;

    // Each cell gets its own constant neighbour taps, so the wrap/clip choice
    // costs nothing at run time and no variable index is needed.
    for (genvar r = 0; r < ROWS; r++) begin : g_row
        for (genvar c = 0; c < COLS; c++) begin : g_col
            localparam int RU = (r == 0)        ? ROWS - 1 : r - 1;
            localparam int RD = (r == ROWS - 1) ? 0        : r + 1;
            localparam int CL = (c == 0)        ? COLS - 1 : c - 1;
            localparam int CR = (c == COLS - 1) ? 0        : c + 1;
`ifdef LIFE_TORUS_EN
            localparam logic HAS_U = 1'b1;
            localparam logic HAS_D = 1'b1;
            localparam logic HAS_L = 1'b1;
            localparam logic HAS_R = 1'b1;
`else
            localparam logic HAS_U = (r != 0);
            localparam logic HAS_D = (r != ROWS - 1);
            localparam logic HAS_L = (c != 0);
            localparam logic HAS_R = (c != COLS - 1);
`endif
            logic [7:0] nb;
            logic [3:0] n;

            assign nb = {grid_q[RU][CL] & HAS_U & HAS_L,
                         grid_q[RU][c]  & HAS_U,
                         grid_q[RU][CR] & HAS_U & HAS_R,
                         grid_q[r][CL]  & HAS_L,
                         grid_q[r][CR]  & HAS_R,
                         grid_q[RD][CL] & HAS_D & HAS_L,
                         grid_q[RD][c]  & HAS_D,
                         grid_q[RD][CR] & HAS_D & HAS_R};
            assign n  = 4'($countones(nb));

            // Born on exactly 3; survives on 2 or 3.
            assign next_grid[r][c] = (n == 4'd3) | (grid_q[r][c] & (n == 4'd2));
        end
    end

    always_comb begin
        // NOTE: defaults first so every path assigns every output -- no latch inferred.
        grid_d   = grid_q;
        loaded_d = loaded_q;
        if (!loaded_q) begin
            grid_d   = ifc.init;
            loaded_d = 1'b1;
        end else begin
            grid_d   = next_grid;
        end
    end

    // NOTE: non-blocking assignments so all cells update from the same old grid.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            grid_q   <= '0;
            loaded_q <= 1'b0;
        end else begin
            grid_q   <= grid_d;
            loaded_q <= loaded_d;
        end
    end

    assign ifc.nextstate = grid_q;

endmodule

// File: tb/tb_life.sv
// Randomised and directed checks of life against a cell-by-cell reference model.
module tb_life;
    localparam int ROWS = 10;
    localparam int COLS = 10;
    localparam int N    = ROWS * COLS;

    typedef logic [ROWS-1:0][COLS-1:0] grid_t;

    logic  clk = 1'b0;
    logic  reset = 1'b0;
    int    n_cmp = 0;
    int    n_bad = 0;
    grid_t exp_g;

    life_if #(.ROWS(ROWS), .COLS(COLS)) bus ();

    life #(.ROWS(ROWS), .COLS(COLS)) dut (
        .clk   (clk),
        .reset (reset),
        .ifc   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [N-1:0] got, input logic [N-1:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    // Reference: count live neighbours directly from Conway's rule.
    function automatic grid_t model_next(input grid_t g);
        grid_t o;
        int    cnt, rr, cc;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                cnt = 0;
                for (int dr = -1; dr <= 1; dr++) begin
                    for (int dc = -1; dc <= 1; dc++) begin
                        if (dr == 0 && dc == 0) continue;
                        rr = r + dr;
                        cc = c + dc;
`ifdef LIFE_TORUS_EN
                        rr = (rr + ROWS) % ROWS;
                        cc = (cc + COLS) % COLS;
`else
                        if (rr < 0 || rr >= ROWS || cc < 0 || cc >= COLS) continue;
`endif
                        if (g[rr][cc]) cnt++;
                    end
                end
                o[r][c] = (cnt == 3) || (g[r][c] && cnt == 2);
            end
        end
        return o;
    endfunction

    function automatic grid_t rand_grid();
        logic [127:0] t;
        t = {$urandom, $urandom, $urandom, $urandom};
        return t[N-1:0];
    endfunction

    // Hold reset with the seed on init, release, and check the load edge.
    task automatic start(input grid_t seed);
        @(negedge clk);
        reset    = 1'b0;
        bus.init = seed;
        #1;
        check("rst_zero", bus.nextstate, '0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("load", bus.nextstate, seed);
        exp_g = seed;
    endtask

    task automatic step(input string tag, input int gens, input logic scramble);
        for (int i = 0; i < gens; i++) begin
            if (scramble) bus.init = rand_grid();
            @(posedge clk);
            #1;
            exp_g = model_next(exp_g);
            check(tag, bus.nextstate, exp_g);
        end
    endtask

    grid_t seed, want;

    initial begin
        bus.init = '0;

        // Reset held over several edges with a nonzero seed
        bus.init = rand_grid() | grid_t'(1);
        repeat (3) @(posedge clk);
        #1;
        check("rst_hold", bus.nextstate, '0);
        start(rand_grid());
        step("rand0", 5, 1'b0);

        // Blinker, period 2
        seed = '0;
        seed[5][5:3] = 3'b111;
        start(seed);
        step("blink_g1", 1, 1'b0);
        want = '0;
        want[4][4] = 1'b1;
        want[5][4] = 1'b1;
        want[6][4] = 1'b1;
        check("blink_g1_shape", bus.nextstate, want);
        step("blink_g2", 1, 1'b0);
        check("blink_g2_shape", bus.nextstate, seed);

        // Block still life
        seed = '0;
        seed[2][3:2] = 2'b11;
        seed[3][3:2] = 2'b11;
        start(seed);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("block", bus.nextstate, seed);
        end

        // Empty seed stays empty; later init changes ignored
        start('0);
        step("empty", 10, 1'b1);
        bus.init = '1;
        repeat (2) @(posedge clk);
        #1;
        check("empty_init_ignored", bus.nextstate, '0);

        // Corner: L-tromino completes to a 2x2 block
        seed = '0;
        seed[0][0] = 1'b1;
        seed[0][1] = 1'b1;
        seed[1][0] = 1'b1;
        want = seed;
        want[1][1] = 1'b1;
        start(seed);
        step("corner_g1", 1, 1'b0);
        check("corner_block", bus.nextstate, want);
        step("corner_g2", 1, 1'b0);
        check("corner_stable", bus.nextstate, want);

        // Vertical blinker on column 0
        seed = '0;
        seed[4][0] = 1'b1;
        seed[5][0] = 1'b1;
        seed[6][0] = 1'b1;
        want = '0;
        want[5][0] = 1'b1;
        want[5][1] = 1'b1;
`ifdef LIFE_TORUS_EN
        want[5][COLS-1] = 1'b1;
`endif
        start(seed);
        step("edge_g1", 1, 1'b0);
        check("edge_g1_shape", bus.nextstate, want);
        step("edge_g2", 1, 1'b0);

        // Asynchronous reset in the middle of generation 3
        seed = rand_grid();
        start(seed);
        step("mid_run", 3, 1'b0);
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("mid_rst_async", bus.nextstate, '0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("mid_reload", bus.nextstate, seed);
        exp_g = seed;
        step("mid_after", 2, 1'b0);

        // Random soups with init scrambled after load
        for (int t = 0; t < 8; t++) begin
            start(rand_grid());
            step("rand", 12, 1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
